note_sequencer: RTL and testbench
=================================

# note_sequencer

Song-playback sequencer for the music player. Steps through the song ROM one note at a time and holds each note for its duration in beat ticks. Presents the current note code and duration to the tone generator and to the song-end judge, together with an address carry-out (`co`). Stops on an end-of-song marker (duration 0), on address wrap, or on an external `song_done`.

## Interface
- `ADDR_W`, default 8: song ROM address width; the ROM holds 2^ADDR_W entries.
- `BEAT_DIV`, default 12500: clock cycles per beat tick, must be at least 2.
- `clk` input, 1 bit: system clock; all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: level-sampled. When high in IDLE or STOP, playback starts from address 0.
- `song_done` input, 1 bit: from the song-end judge. When high in FETCH, LOAD or PLAY, playback is aborted.
- `rom_addr` output, ADDR_W bits: song ROM address, registered.
- `rom_data` input, 12 bits: ROM word. Bits [11:6] are the note code, bits [5:0] are the duration in beats. The ROM is synchronous with 1-cycle read latency.
- `note_code` output, 6 bits: current note; 0 means rest.
- `duration` output, 6 bits: the loaded duration of the current note, held for the whole note. This is not a countdown.
- `co` output, 1 bit: single-cycle pulse when `rom_addr` wraps from 2^ADDR_W−1 to 0.
- `note_valid` output, 1 bit: high only in PLAY.
- `playing` output, 1 bit: high in FETCH, LOAD and PLAY.

## Operation
- States:
  - **IDLE**: the state after reset.
  - **FETCH**: `rom_addr` is stable and the ROM read is in flight.
  - **LOAD**: `rom_data` is captured.
  - **PLAY**: the note is counted out in beats.
  - **STOP**: playback has finished.
- Transitions:
  - IDLE or STOP to FETCH when `start`=1; `rom_addr` is set to 0 at that edge.
  - FETCH always goes to LOAD.
  - LOAD: `note_code` and `duration` are registered from `rom_data`.
    - If `rom_data[5:0]`=0 (end marker), go to STOP.
    - Otherwise go to PLAY with the beat counter loaded with the duration and the prescaler cleared.
  - PLAY counts down one beat per prescaler tick. At the tick that takes the beat count from 1 to 0:
    - `rom_addr` increments and the state goes to FETCH.
    - If `rom_addr` was at maximum, it wraps to 0, `co` pulses in the following cycle, and the next state depends on the configuration.
  - `song_done`=1 in FETCH, LOAD or PLAY goes to STOP. This takes priority over every other transition except `rst`.
- In STOP:
  - `duration` is forced to 0 and `note_code` to 0.
  - The state stays in STOP until `start`.
- `rst` at any point, including mid-note, returns to IDLE next cycle.
- Reset values of all outputs: `rom_addr`=0, `note_code`=0, `duration`=0, `co`=0, `note_valid`=0, `playing`=0.
- Arithmetic:
  - Beat counter is 6 bits.
  - Prescaler is ceil(log2(BEAT_DIV)) bits and counts 0 to BEAT_DIV−1. The tick fires when the prescaler reaches BEAT_DIV−1.
  - `rom_addr` increments modulo 2^ADDR_W.

## Timing
- A `start` sampled at edge 0 gives:
  - FETCH in cycle 1, with `rom_addr`=0 valid.
  - LOAD in cycle 2, with `rom_data` valid and captured.
  - PLAY from cycle 3, with `note_valid`=1.
- Each note occupies exactly duration×BEAT_DIV cycles in PLAY.
- There is a 2-cycle gap (FETCH, LOAD) between notes. During the gap, `note_valid`=0 and `note_code` and `duration` hold the previous values.
- An end marker read in LOAD gives STOP in the next cycle, with `duration`=0 visible in that cycle.
- `song_done` sampled high gives STOP in the next cycle.
- `start` held high in STOP restarts the song immediately; it is level-sensitive, not edge-detected.

## Configuration
- `NOTE_SEQ_LOOP_EN` defined: address wrap continues into FETCH at address 0, so the song loops. `co` still pulses on each wrap.
- `NOTE_SEQ_LOOP_EN` undefined: address wrap goes to STOP. `co` pulses in the first STOP cycle.
- The end marker and `song_done` always stop playback in both builds.

## Structure
- Shared package `music_pkg` holds:
  - state encodings (IDLE=0, FETCH=1, LOAD=2, PLAY=3, STOP=4; 3 bits);
  - field widths NOTE_W=6 and DUR_W=6;
  - the ROM word layout (note field [11:6], duration field [5:0]).
- Sub-module `beat_prescaler` with ports clk, rst, clear, enable and tick. It generates a one-cycle `tick` every BEAT_DIV enabled cycles. `clear` zeroes its count.

## Test plan
- **Basic note:** BEAT_DIV=4; ROM[0]=note 5, duration 3; ROM[1]=duration 0. Pulse `start` → `note_valid` high for exactly 12 cycles from cycle 3 with `note_code`=5 and `duration`=3; then FETCH, LOAD, STOP; `duration`=0 and `playing`=0.
- **Multi-note sequence:** ROM[0..2] = durations 1, 2, 1, then an end marker → PLAY lengths of 4, 8 and 4 cycles, each separated by a 2-cycle `note_valid`=0 gap.
- **Wrap:** ADDR_W=2, all four entries with duration 1. Without `NOTE_SEQ_LOOP_EN`: one `co` pulse, then STOP. With `NOTE_SEQ_LOOP_EN`: `co` pulses every 4 notes and playback continues.
- **Abort:** `song_done`=1 mid-PLAY at beat 2 of 5 → STOP next cycle, `note_code`=0, `duration`=0; a later `start` restarts from `rom_addr`=0.
- **Reset mid-note:** `rst` in PLAY → next cycle all outputs at reset values and state IDLE; a following `start` plays ROM[0] from the beginning.
- **Immediate end:** ROM[0] duration 0 → no PLAY state; STOP reached at cycle 3 with `note_valid` never asserted.

Source files
------------

// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module   : music_pkg
// Purpose  : Shared types and ROM word layout for the song sequencer.
// Revision : 1.0
// ============================================================================
package music_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int ROM_W  = NOTE_W + DUR_W;

    localparam int NOTE_HI = 11;
    localparam int NOTE_LO = 6;
    localparam int DUR_HI  = 5;
    localparam int DUR_LO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_STOP  = 3'd4
    } seq_state_t;

    function automatic logic [NOTE_W-1:0] word_note(input logic [ROM_W-1:0] w);
        return w[NOTE_HI:NOTE_LO];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [ROM_W-1:0] w);
        return w[DUR_HI:DUR_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer_if
// Purpose  : Control, ROM and note-output bundle of the song sequencer.
// Revision : 1.0
// ============================================================================
interface note_sequencer_if #(
    parameter int ADDR_W = 8
);
    import music_pkg::*;

    logic                start;
    logic                song_done;
    logic [ADDR_W-1:0]   rom_addr;
    logic [ROM_W-1:0]    rom_data;
    logic [NOTE_W-1:0]   note_code;
    logic [DUR_W-1:0]    duration;
    logic                co;
    logic                note_valid;
    logic                playing;

    modport master (
        output start, song_done, rom_data,
        input  rom_addr, note_code, duration, co, note_valid, playing
    );

    modport slave (
        input  start, song_done, rom_data,
        output rom_addr, note_code, duration, co, note_valid, playing
    );

endinterface
`default_nettype wire

// File: rtl/beat_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : beat_prescaler
// Purpose  : One-cycle tick every BEAT_DIV enabled cycles; clear restarts count.
// Revision : 1.0
// ============================================================================
module beat_prescaler #(
    parameter int BEAT_DIV = 12500
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W   = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEAT_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Purpose  : Steps through the song ROM, holding each note for its beat count.
//            Build option NOTE_SEQ_LOOP_EN: address wrap loops the song
//            instead of stopping.
// Revision : 1.0
// ============================================================================
module note_sequencer
    import music_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int BEAT_DIV = 12500
) (
    input  logic             clk,
    input  logic             rst,
    note_sequencer_if.slave  sif
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    seq_state_t          state_q,     state_d;
    logic [ADDR_W-1:0]   rom_addr_q,  rom_addr_d;
    logic [NOTE_W-1:0]   note_code_q, note_code_d;
    logic [DUR_W-1:0]    duration_q,  duration_d;
    logic [DUR_W-1:0]    beat_q,      beat_d;
    logic                co_q,        co_d;

    logic                tick;
    logic                presc_clear;
    logic                presc_en;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;

    assign rom_note    = word_note(sif.rom_data);
    assign rom_dur     = word_dur(sif.rom_data);
    assign presc_clear = (state_q == ST_LOAD);
    assign presc_en    = (state_q == ST_PLAY);

    beat_prescaler #(
        .BEAT_DIV (BEAT_DIV)
    ) u_beat_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (presc_clear),
        .enable (presc_en),
        .tick   (tick)
    );

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        note_code_d = note_code_q;
        duration_d  = duration_q;
        beat_d      = beat_q;
        co_d        = 1'b0;

        case (state_q)
            ST_IDLE, ST_STOP: begin
                if (sif.start) begin
                    state_d    = ST_FETCH;
                    rom_addr_d = '0;
                end
            end
            ST_FETCH: begin
                state_d = sif.song_done ? ST_STOP : ST_LOAD;
            end
            ST_LOAD: begin
                if (sif.song_done || rom_dur == '0) begin
                    state_d = ST_STOP;
                end else begin
                    state_d     = ST_PLAY;
                    note_code_d = rom_note;
                    duration_d  = rom_dur;
                    beat_d      = rom_dur;
                end
            end
            ST_PLAY: begin
                if (sif.song_done) begin
                    state_d = ST_STOP;
                end else if (tick) begin
                    if (beat_q == DUR_W'(1)) begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = ST_FETCH;
                        if (rom_addr_q == ADDR_MAX) begin
                            co_d = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                            state_d = ST_FETCH;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                    beat_d = beat_q - DUR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every entry into (or stay in) STOP blanks the presented note.
        if (state_d == ST_STOP) begin
            note_code_d = '0;
            duration_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            note_code_q <= '0;
            duration_q  <= '0;
            beat_q      <= '0;
            co_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            note_code_q <= note_code_d;
            duration_q  <= duration_d;
            beat_q      <= beat_d;
            co_q        <= co_d;
        end
    end

    assign sif.rom_addr   = rom_addr_q;
    assign sif.note_code  = note_code_q;
    assign sif.duration   = duration_q;
    assign sif.co         = co_q;
    assign sif.note_valid = (state_q == ST_PLAY);
    assign sif.playing    = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                            (state_q == ST_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_sequencer
// Purpose  : Scoreboard bench for note_sequencer (ADDR_W=2, BEAT_DIV=4).
// Revision : 1.0
// ============================================================================
module tb_note_sequencer;

    localparam int ADDR_W   = 2;
    localparam int BEAT_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    note_sequencer #(
        .ADDR_W   (ADDR_W),
        .BEAT_DIV (BEAT_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (bus)
    );

    logic [11:0] rom [0:3];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks  = 0;
    int errors  = 0;
    int co_seen = 0;
    int nv_seen = 0;

    always @(negedge clk) begin
        if (bus.co === 1'b1)         co_seen++;
        if (bus.note_valid === 1'b1) nv_seen++;
    end

    typedef struct {
        int code;
        int dur;
        int len;
    } note_t;
    note_t sb[$];

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [11:0] word(input int code, input int dur);
        logic [5:0] c;
        logic [5:0] d;
        c = code[5:0];
        d = dur[5:0];
        return {c, d};
    endfunction

    task automatic push_note(input int code, input int dur);
        note_t n;
        n.code = code;
        n.dur  = dur;
        n.len  = dur * BEAT_DIV;
        sb.push_back(n);
    endtask

    task automatic load_rom(input logic [11:0] w0, input logic [11:0] w1,
                            input logic [11:0] w2, input logic [11:0] w3);
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
        rom[3] = w3;
    endtask

    task automatic start_song();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_rise(input string tag);
        int k;
        k = 0;
        while (bus.note_valid !== 1'b1 && k < 10) begin
            k++;
            step();
        end
        check({tag, "_rise"}, int'(bus.note_valid), 1);
    endtask

    // Measures one PLAY run (gap before it, length, held code/duration) and
    // retires the oldest scoreboard entry against it.
    task automatic play_note(input string tag);
        int    gap;
        int    len;
        int    c0;
        int    d0;
        int    dl;
        note_t e;
        gap = 0;
        len = 0;
        dl  = 0;
        while (bus.note_valid !== 1'b1 && gap < 10) begin
            gap++;
            step();
        end
        check({tag, "_rise"}, int'(bus.note_valid), 1);
        check({tag, "_gap"}, gap, 2);
        c0 = int'(bus.note_code);
        d0 = int'(bus.duration);
        while (bus.note_valid === 1'b1 && len < 400) begin
            dl = int'(bus.duration);
            len++;
            step();
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_code"}, c0, e.code);
            check({tag, "_dur"}, d0, e.dur);
            check({tag, "_dur_end"}, dl, e.dur);
            check({tag, "_len"}, len, e.len);
        end
    endtask

    task automatic expect_stop(input string tag);
        check({tag, "_playing"}, int'(bus.playing), 0);
        check({tag, "_nv"}, int'(bus.note_valid), 0);
        check({tag, "_code"}, int'(bus.note_code), 0);
        check({tag, "_dur"}, int'(bus.duration), 0);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, "_addr"}, int'(bus.rom_addr), 0);
        check({tag, "_co"}, int'(bus.co), 0);
        expect_stop(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int co0;
        int nv0;
        bus.start     = 1'b0;
        bus.song_done = 1'b0;
        load_rom(word(5, 3), 12'h000, 12'h000, 12'h000);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        expect_reset("reset");

        // Basic note then end marker.
        push_note(5, 3);
        start_song();
        check("basic_fetch_addr", int'(bus.rom_addr), 0);
        check("basic_fetch_playing", int'(bus.playing), 1);
        play_note("basic");
        check("basic_next_addr", int'(bus.rom_addr), 1);
        check("basic_gap_playing", int'(bus.playing), 1);
        check("basic_gap_code", int'(bus.note_code), 5);
        step();
        step();
        expect_stop("basic_stop");
        step();
        step();
        expect_stop("basic_stop_hold");

        // Multi-note sequence.
        load_rom(word(1, 1), word(2, 2), word(3, 1), 12'h000);
        push_note(1, 1);
        push_note(2, 2);
        push_note(3, 1);
        start_song();
        play_note("multi0");
        play_note("multi1");
        play_note("multi2");
        step();
        step();
        expect_stop("multi_stop");

        // Address wrap.
        load_rom(word(7, 1), word(8, 1), word(9, 1), word(10, 1));
        co0 = co_seen;
        for (int i = 0; i < 4; i++) push_note(7 + i, 1);
        start_song();
        for (int i = 0; i < 4; i++) play_note("wrap");
        check("wrap_co", int'(bus.co), 1);
        check("wrap_addr", int'(bus.rom_addr), 0);
`ifdef NOTE_SEQ_LOOP_EN
        check("wrap_loop_playing", int'(bus.playing), 1);
        for (int i = 0; i < 4; i++) push_note(7 + i, 1);
        for (int i = 0; i < 4; i++) play_note("loop");
        check("loop_co_count", co_seen - co0, 2);
        bus.song_done = 1'b1;
        step();
        bus.song_done = 1'b0;
        expect_stop("loop_abort");
`else
        expect_stop("wrap_stop");
        step();
        check("wrap_co_single", int'(bus.co), 0);
        check("wrap_co_count", co_seen - co0, 1);
`endif

        // Abort mid-note, then restart.
        load_rom(word(4, 5), 12'h000, 12'h000, 12'h000);
        start_song();
        wait_rise("abort");
        for (int i = 0; i < BEAT_DIV + 1; i++) step();
        bus.song_done = 1'b1;
        step();
        bus.song_done = 1'b0;
        expect_stop("abort_stop");
        step();
        step();
        expect_stop("abort_hold");
        push_note(4, 5);
        start_song();
        check("restart_addr", int'(bus.rom_addr), 0);
        play_note("restart");
        step();
        step();
        expect_stop("restart_stop");

        // Reset mid-note.
        load_rom(word(9, 3), 12'h000, 12'h000, 12'h000);
        start_song();
        wait_rise("rstmid");
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        expect_reset("rstmid");
        rst = 1'b0;
        step();
        check("rstmid_idle", int'(bus.playing), 0);
        push_note(9, 3);
        start_song();
        check("rstmid_addr", int'(bus.rom_addr), 0);
        play_note("rstmid_replay");
        step();
        step();
        expect_stop("rstmid_stop");

        // Immediate end marker.
        load_rom(word(11, 0), word(12, 2), 12'h000, 12'h000);
        nv0 = nv_seen;
        start_song();
        check("imm_fetch_playing", int'(bus.playing), 1);
        step();
        step();
        expect_stop("imm_stop");
        step();
        check("imm_nv_never", nv_seen - nv0, 0);
        check("imm_sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
